// File: rtl/wb_pkg.sv
// Shared types and widths for the writeback arbiter slice.
package wb_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [DATA_W-1:0]     data;
  } wb_req_t;

  typedef enum logic [1:0] {
    IDLE,
    COUNT,
    DRAIN
  } wb_state_e;

endpackage

// File: rtl/wb_arbiter_if.sv
// Bus bundle between the pipeline/multdiv producers and the writeback arbiter.
interface wb_arbiter_if #(
  parameter int FIFO_DEPTH = 2
);
  import wb_pkg::*;

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  logic                  pipe_we;
  logic [REG_ADDR_W-1:0] pipe_rd;
  logic [DATA_W-1:0]     pipe_data;
  logic                  md_valid;
  logic                  md_ready;
  logic [REG_ADDR_W-1:0] md_rd;
  logic [DATA_W-1:0]     md_data;
  logic                  stall_pipe;
  logic                  ctrl_writeEnable;
  logic [REG_ADDR_W-1:0] ctrl_writeReg;
  logic [DATA_W-1:0]     data_writeReg;
  logic [CNT_W-1:0]      fifo_count;

  modport slave (
    input  pipe_we, pipe_rd, pipe_data, md_valid, md_rd, md_data,
    output md_ready, stall_pipe, ctrl_writeEnable, ctrl_writeReg, data_writeReg, fifo_count
  );

  modport master (
    output pipe_we, pipe_rd, pipe_data, md_valid, md_rd, md_data,
    input  md_ready, stall_pipe, ctrl_writeEnable, ctrl_writeReg, data_writeReg, fifo_count
  );

endinterface

// File: rtl/wb_fifo.sv
// In-order buffer for multdiv results awaiting a free register-file write slot.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                         clock,
  input  logic                         ctrl_reset_n,
  input  logic                         push,
  input  logic                         pop,
  input  wb_req_t                      wrData,
  output wb_req_t                      rdData,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  wb_req_t          mem [DEPTH];
  logic [PTR_W-1:0] wrPtr;
  logic [PTR_W-1:0] rdPtr;
  logic             doPush;
  logic             doPop;

  // Pointers wrap explicitly so non-power-of-two depths stay in range.
  function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + 1'b1;
  endfunction

  assign full   = (count == CNT_W'(DEPTH));
  assign empty  = (count == '0);
  assign doPush = push && !full;
  assign doPop  = pop && !empty;
  assign rdData = mem[rdPtr];

  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= nextPtr(wrPtr);
      if (doPop)  rdPtr <= nextPtr(rdPtr);
      case ({doPush, doPop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (doPush) mem[wrPtr] <= wrData;
  end

endmodule

// File: rtl/wb_arbiter.sv
// Register-file writeback arbiter: pipeline first, buffered multdiv results otherwise.
// Define WB_STARVE_GUARD_EN to add the IDLE/COUNT/DRAIN starvation guard.
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic          clock,
  input  logic          ctrl_reset_n,
  wb_arbiter_if.slave   bus
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  wb_req_t               headReq;
  wb_req_t               pushReq;
  logic                  fifoFull;
  logic                  fifoEmpty;
  logic                  fifoPush;
  logic                  fifoPop;
  logic [CNT_W-1:0]      fifoCount;
  logic                  pipeWin;
  logic                  readyEn;
  logic                  stallPipe;
  logic                  writeEnableQ;
  logic [REG_ADDR_W-1:0] writeRegQ;
  logic [DATA_W-1:0]     writeDataQ;

  // md_ready is built only from flops so producers see no combinational loop.
  assign bus.md_ready = readyEn && !fifoFull;
  assign pipeWin      = bus.pipe_we && (bus.pipe_rd != '0) && !stallPipe;
  assign fifoPop      = !pipeWin && !fifoEmpty;
  assign fifoPush     = bus.md_valid && bus.md_ready && (bus.md_rd != '0);
  assign pushReq      = '{rd: bus.md_rd, data: bus.md_data};

  wb_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) fifo (
    .clock        (clock),
    .ctrl_reset_n (ctrl_reset_n),
    .push         (fifoPush),
    .pop          (fifoPop),
    .wrData       (pushReq),
    .rdData       (headReq),
    .full         (fifoFull),
    .empty        (fifoEmpty),
    .count        (fifoCount)
  );

  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) readyEn <= 1'b0;
    else               readyEn <= 1'b1;
  end

  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      writeEnableQ <= 1'b0;
      writeRegQ    <= '0;
      writeDataQ   <= '0;
    end else if (pipeWin) begin
      writeEnableQ <= 1'b1;
      writeRegQ    <= bus.pipe_rd;
      writeDataQ   <= bus.pipe_data;
    end else if (!fifoEmpty) begin
      writeEnableQ <= 1'b1;
      writeRegQ    <= headReq.rd;
      writeDataQ   <= headReq.data;
    end else begin
      writeEnableQ <= 1'b0;
    end
  end

`ifdef WB_STARVE_GUARD_EN
  localparam int SC_W = $clog2(STARVE_LIMIT + 1);

  wb_state_e        state;
  wb_state_e        nextState;
  logic [SC_W-1:0]  starveCnt;
  logic [SC_W-1:0]  nextCnt;
  logic             wonWhileBusy;

  assign wonWhileBusy = pipeWin && !fifoEmpty;

  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      state     <= IDLE;
      starveCnt <= '0;
    end else begin
      state     <= nextState;
      starveCnt <= nextCnt;
    end
  end

  // Any cycle the pipeline does not win over a waiting result resets the streak.
  always_comb begin
    nextState = IDLE;
    nextCnt   = '0;
    case (state)
      IDLE, COUNT: begin
        if (wonWhileBusy) begin
          nextCnt   = starveCnt + 1'b1;
          nextState = (nextCnt >= SC_W'(STARVE_LIMIT)) ? DRAIN : COUNT;
        end
      end
      DRAIN: begin
        nextState = IDLE;
        nextCnt   = '0;
      end
      default: begin
        nextState = IDLE;
        nextCnt   = '0;
      end
    endcase
  end

  always_comb begin
    stallPipe = (state == DRAIN);
  end
`else
  logic unusedStarveLimit;

  assign stallPipe         = 1'b0;
  assign unusedStarveLimit = ^STARVE_LIMIT;
`endif

  assign bus.stall_pipe       = stallPipe;
  assign bus.ctrl_writeEnable = writeEnableQ;
  assign bus.ctrl_writeReg    = writeRegQ;
  assign bus.data_writeReg    = writeDataQ;
  assign bus.fifo_count       = fifoCount;

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter against a queue-based writeback model.
// Builds with or without WB_STARVE_GUARD_EN.
module tb_wb_arbiter;
  import wb_pkg::*;

  localparam int FIFO_DEPTH   = 2;
  localparam int STARVE_LIMIT = 4;

  logic clock = 1'b0;
  logic ctrl_reset_n;
  int   checkCount = 0;
  int   errorCount = 0;

  wb_arbiter_if #(.FIFO_DEPTH(FIFO_DEPTH)) bus ();

  wb_arbiter #(
    .FIFO_DEPTH   (FIFO_DEPTH),
    .STARVE_LIMIT (STARVE_LIMIT)
  ) dut (
    .clock        (clock),
    .ctrl_reset_n (ctrl_reset_n),
    .bus          (bus.slave)
  );

  always #5 clock = ~clock;

  // Model state: pending results in order, last register-file write, starvation streak.
  wb_req_t     mq[$];
  bit          mOut;
  bit          mStall;
  int          mCnt;
  bit          mWe;
  logic [4:0]  mAddr;
  logic [31:0] mData;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic resetModel();
    mq.delete();
    mOut   = 1'b0;
    mStall = 1'b0;
    mCnt   = 0;
    mWe    = 1'b0;
    mAddr  = '0;
    mData  = '0;
  endtask

  // Drives one cycle of inputs, advances the model, then compares after the edge.
  task automatic applyStimulus(input logic we, input logic [4:0] prd, input logic [31:0] pdata,
                               input logic mv, input logic [4:0] mrd, input logic [31:0] mdata);
    bit      readyNow;
    bit      win;
    bit      nonEmpty;
    wb_req_t head;
    bus.pipe_we   = we;
    bus.pipe_rd   = prd;
    bus.pipe_data = pdata;
    bus.md_valid  = mv;
    bus.md_rd     = mrd;
    bus.md_data   = mdata;
    readyNow = mOut && (mq.size() < FIFO_DEPTH);
    win      = we && (prd != 0) && !mStall;
    nonEmpty = (mq.size() > 0);
    if (win) begin
      mWe = 1'b1; mAddr = prd; mData = pdata;
    end else if (nonEmpty) begin
      head = mq.pop_front();
      mWe = 1'b1; mAddr = head.rd; mData = head.data;
    end else begin
      mWe = 1'b0;
    end
`ifdef WB_STARVE_GUARD_EN
    if (mStall) begin
      mStall = 1'b0;
      mCnt   = 0;
    end else if (win && nonEmpty) begin
      mCnt++;
      if (mCnt >= STARVE_LIMIT) mStall = 1'b1;
    end else begin
      mCnt = 0;
    end
`endif
    if (mv && readyNow && (mrd != 0)) mq.push_back(wb_req_t'{rd: mrd, data: mdata});
    mOut = 1'b1;
    @(posedge clock);
    #1;
    checkOutput("we", 64'(bus.ctrl_writeEnable), 64'(mWe));
    checkOutput("addr", 64'(bus.ctrl_writeReg), 64'(mAddr));
    checkOutput("data", 64'(bus.data_writeReg), 64'(mData));
    checkOutput("count", 64'(bus.fifo_count), 64'(mq.size()));
    checkOutput("ready", 64'(bus.md_ready), 64'(mq.size() < FIFO_DEPTH));
    checkOutput("stall", 64'(bus.stall_pipe), 64'(mStall));
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  initial begin
    bus.pipe_we = 1'b0; bus.pipe_rd = '0; bus.pipe_data = '0;
    bus.md_valid = 1'b0; bus.md_rd = '0; bus.md_data = '0;
    ctrl_reset_n = 1'b1;
    resetModel();
    #2 ctrl_reset_n = 1'b0;
    #1;
    checkOutput("rst_we", 64'(bus.ctrl_writeEnable), 64'd0);
    checkOutput("rst_ready", 64'(bus.md_ready), 64'd0);
    checkOutput("rst_count", 64'(bus.fifo_count), 64'd0);
    checkOutput("rst_stall", 64'(bus.stall_pipe), 64'd0);
    repeat (2) @(posedge clock);
    #3 ctrl_reset_n = 1'b1;
    checkOutput("rel_ready_before_edge", 64'(bus.md_ready), 64'd0);
    idleCycles(1);
    checkOutput("rel_ready_after_edge", 64'(bus.md_ready), 64'd1);

    // Pipeline write appears one edge after it is presented.
    applyStimulus(1'b1, 5'd3, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0);
    checkOutput("pipe_we", 64'(bus.ctrl_writeEnable), 64'd1);
    checkOutput("pipe_rd", 64'(bus.ctrl_writeReg), 64'd3);
    checkOutput("pipe_data", 64'(bus.data_writeReg), 64'hDEADBEEF);

    // rd=0 pipeline request is dropped; the multdiv result lands two edges later.
    applyStimulus(1'b1, 5'd0, 32'h1234, 1'b1, 5'd7, 32'h5);
    checkOutput("drop_rd0_we", 64'(bus.ctrl_writeEnable), 64'd0);
    idleCycles(1);
    checkOutput("md_lat_we", 64'(bus.ctrl_writeEnable), 64'd1);
    checkOutput("md_lat_rd", 64'(bus.ctrl_writeReg), 64'd7);
    checkOutput("md_lat_data", 64'(bus.data_writeReg), 64'h5);
    idleCycles(2);

`ifndef WB_STARVE_GUARD_EN
    applyStimulus(1'b1, 5'd1, 32'h100, 1'b1, 5'd10, 32'hA0);
    applyStimulus(1'b1, 5'd2, 32'h200, 1'b1, 5'd11, 32'hB1);
    checkOutput("full_ready", 64'(bus.md_ready), 64'd0);
    for (int i = 3; i <= 5; i++) begin
      applyStimulus(1'b1, 5'(i), 32'(i), 1'b1, 5'd12, 32'hC2);
      checkOutput("pipe_owns_slot", 64'(bus.ctrl_writeReg), 64'(i));
      checkOutput("held_ready", 64'(bus.md_ready), 64'd0);
    end
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    checkOutput("order_first_rd", 64'(bus.ctrl_writeReg), 64'd10);
    checkOutput("order_first_data", 64'(bus.data_writeReg), 64'hA0);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    checkOutput("order_second_rd", 64'(bus.ctrl_writeReg), 64'd11);
    checkOutput("order_second_data", 64'(bus.data_writeReg), 64'hB1);
    idleCycles(2);
`else
    applyStimulus(1'b1, 5'd1, 32'h100, 1'b1, 5'd12, 32'hC0FFEE);
    for (int i = 2; i <= 4; i++) begin
      applyStimulus(1'b1, 5'(i), 32'(i), 1'b0, 5'd0, 32'd0);
      checkOutput("stall_early", 64'(bus.stall_pipe), 64'd0);
    end
    applyStimulus(1'b1, 5'd5, 32'h5, 1'b0, 5'd0, 32'd0);
    checkOutput("stall_raised", 64'(bus.stall_pipe), 64'd1);
    applyStimulus(1'b1, 5'd6, 32'h6, 1'b0, 5'd0, 32'd0);
    checkOutput("drain_rd", 64'(bus.ctrl_writeReg), 64'd12);
    checkOutput("drain_data", 64'(bus.data_writeReg), 64'hC0FFEE);
    checkOutput("stall_cleared", 64'(bus.stall_pipe), 64'd0);
    checkOutput("drain_count", 64'(bus.fifo_count), 64'd0);
    idleCycles(2);
`endif

    // Asynchronous reset with two results buffered must discard them.
    applyStimulus(1'b1, 5'd1, 32'h11, 1'b1, 5'd20, 32'h20);
    applyStimulus(1'b1, 5'd2, 32'h22, 1'b1, 5'd21, 32'h21);
    checkOutput("pre_rst_count", 64'(bus.fifo_count), 64'd2);
    #2 ctrl_reset_n = 1'b0;
    #1;
    checkOutput("async_we", 64'(bus.ctrl_writeEnable), 64'd0);
    checkOutput("async_addr", 64'(bus.ctrl_writeReg), 64'd0);
    checkOutput("async_data", 64'(bus.data_writeReg), 64'd0);
    checkOutput("async_count", 64'(bus.fifo_count), 64'd0);
    checkOutput("async_ready", 64'(bus.md_ready), 64'd0);
    checkOutput("async_stall", 64'(bus.stall_pipe), 64'd0);
    resetModel();
    @(posedge clock);
    #3 ctrl_reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      checkOutput("no_write_after_rst", 64'(bus.ctrl_writeEnable), 64'd0);
    end

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      logic        we, mv;
      logic [4:0]  prd, mrd;
      we  = 1'($urandom_range(0, 1));
      prd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      mv  = 1'($urandom_range(0, 1));
      mrd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      applyStimulus(we, prd, $urandom, mv, mrd, $urandom);
    end
    idleCycles(4);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 The block SHALL have parameter FIFO_DEPTH, default 2: multdiv result buffer entries, minimum 1.
REQ-002 The block SHALL have parameter STARVE_LIMIT, default 4: consecutive pipeline-won cycles before a forced drain.
REQ-003 Port clock  input  1  the single clock; all state SHALL update on its rising edge.
REQ-004 Port ctrl_reset_n  input  1  asynchronous, active-low reset.
REQ-005 Port pipe_we  input  1  pipeline writeback request this cycle.
REQ-006 Port pipe_rd  input  5  pipeline destination register.
REQ-007 Port pipe_data  input  32  pipeline write data.
REQ-008 Port md_valid  input  1  multdiv result valid.
REQ-009 Port md_ready  output  1  buffer can accept a multdiv result.
REQ-010 Port md_rd  input  5  multdiv destination register.
REQ-011 Port md_data  input  32  multdiv result data.
REQ-012 Port stall_pipe  output  1  pipeline shall hold its writeback.
REQ-013 Port ctrl_writeEnable  output  1  register-file write enable.
REQ-014 Port ctrl_writeReg  output  5  register-file write address.
REQ-015 Port data_writeReg  output  32  register-file write data.
REQ-016 Port fifo_count  output  $clog2(FIFO_DEPTH+1)  current buffer occupancy.

Function
REQ-017 ctrl_writeEnable, ctrl_writeReg and data_writeReg SHALL be registered, with the write appearing one cycle after the request is selected.
REQ-018 Selection priority SHALL be: pipeline request (pipe_we=1, pipe_rd!=0, stall_pipe=0) first, then FIFO head if non-empty, else no write (ctrl_writeEnable=0, address and data hold their previous values).
REQ-019 A pipeline request with pipe_rd=0 SHALL be dropped and SHALL NOT consume the write slot.
REQ-020 md_ready SHALL equal (fifo_count<FIFO_DEPTH) and SHALL depend only on registered state, with no combinational path from md_valid or pipe_we.
REQ-021 A multdiv result SHALL be accepted when md_valid=1 and md_ready=1; md_rd=0 results SHALL be accepted and discarded, not pushed.
REQ-022 An accepted result SHALL NOT bypass the FIFO, giving a minimum latency from md_valid to ctrl_writeEnable of 2 cycles.
REQ-023 The FIFO SHALL be in-order; a pop and a push in the same cycle SHALL leave fifo_count unchanged.
REQ-024 When the FIFO is full, md_ready SHALL be 0 even in a cycle that pops.
REQ-025 FIFO read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-026 Write-after-write ordering between pipeline and multdiv writes to the same register SHALL be the upstream's responsibility, and the block SHALL NOT check it.

Reset
REQ-027 While ctrl_reset_n=0, the block SHALL force ctrl_writeEnable=0, ctrl_writeReg=0, data_writeReg=0, stall_pipe=0, fifo_count=0, md_ready=0, pointers=0, starve counter=0, and FSM=IDLE, immediately and without waiting for clock.
REQ-028 Reset asserted mid-operation SHALL discard all buffered results.
REQ-029 md_ready SHALL rise on the first clock edge after ctrl_reset_n deasserts.

Configuration
REQ-030 When WB_STARVE_GUARD_EN is defined, the block SHALL include FSM IDLE/COUNT/DRAIN:
- IDLE->COUNT when the pipeline wins and the FIFO is non-empty.
- COUNT increments per such cycle and returns to IDLE when the FIFO empties or the pipeline does not win.
- Reaching STARVE_LIMIT moves to DRAIN and registers stall_pipe=1.
- In DRAIN, pipe_we SHALL be ignored and exactly one FIFO entry popped, then the FSM returns to IDLE, stall_pipe=0 and the counter clears.
REQ-031 When WB_STARVE_GUARD_EN is undefined, stall_pipe SHALL be tied to 0, no FSM or counter logic SHALL exist, and pipeline priority SHALL be absolute.

Structure
REQ-032 Package wb_pkg SHALL hold REG_ADDR_W=5, DATA_W=32, typedef wb_req_t {rd, data}, and the FSM state enum.
REQ-033 The FIFO SHALL be sub-module wb_fifo (parameter DEPTH, push/pop/full/empty/count), instantiated once.

Verification
REQ-034 The bench SHALL apply pipe_we=1, rd=3, data=0xDEADBEEF at cycle N and check ctrl_writeEnable=1, writeReg=3, data=0xDEADBEEF at N+1.
REQ-035 The bench SHALL apply pipe_we=1, rd=0 and md_valid=1, rd=7, data=0x5 at the same cycle and check the rd=0 write is dropped and rd=7 is written 2 cycles later.
REQ-036 The bench SHALL push 2 multdiv results while the pipeline writes every cycle (guard disabled) and check md_ready=0 with a third held, then no md write until pipe_we drops, then writes in push order.
REQ-037 With WB_STARVE_GUARD_EN and STARVE_LIMIT=4, the bench SHALL drive continuous pipe_we with the FIFO non-empty and check stall_pipe=1 after 4 won cycles, one FIFO write, then stall_pipe=0.
REQ-038 The bench SHALL assert ctrl_reset_n=0 asynchronously between clock edges with fifo_count=2 and check all outputs 0 immediately, and no buffered write after release.
